traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameters SHALL be:
  RED_TICKS, 10, nominal red phase length in clock cycles
  GREEN_TICKS, 8, nominal green phase length in clock cycles
  YELLOW_TICKS, 3, nominal yellow phase length in clock cycles
  TOL, 1, allowed deviation in cycles; legal length is [X_TICKS-TOL, X_TICKS+TOL]
REQ-002 Ports SHALL be:
  clock  input  1  single clock; all logic on rising edge
  reset  input  1  synchronous, active-high reset
  red  input  1  observed red lamp
  green  input  1  observed green lamp
  yellow  input  1  observed yellow lamp
  phase  output  2  tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW
  fault  output  1  sticky fault flag
  fault_code  output  3  0 none, 1 not one-hot, 2 illegal order, 3 too short, 4 too long
  cycle_count  output  8  completed full red-green-yellow cycles
  last_len  output  8  length of the most recently completed phase

Function
REQ-003 Lamp inputs SHALL be registered in stage 1; state, counter and outputs SHALL update from stage 1 on the next edge (fault visible after the 2nd rising edge following the offending pattern).
REQ-004 FSM states SHALL be SYNC, RED, GREEN, YELLOW, FAULT; FAULT is reported as phase of the last valid state.
REQ-005 In SYNC, the first sampled one-hot pattern SHALL enter the matching phase; all-zero or multi-hot patterns SHALL keep SYNC without fault.
REQ-006 The first phase entered from SYNC SHALL NOT be length-checked (partial phase); all later phases SHALL be.
REQ-007 Legal transitions SHALL be RED->GREEN, GREEN->YELLOW, YELLOW->RED only.
REQ-008 Phase counter SHALL load 1 on phase entry, increment per cycle the sample matches the phase, and saturate at 255.
REQ-009 Outside SYNC, a non-one-hot sample SHALL set fault_code 1.
REQ-010 A one-hot sample of an illegal next phase SHALL set fault_code 2.
REQ-011 A legal transition with completed length < X_TICKS-TOL SHALL set fault_code 3.
REQ-012 When the counter would reach X_TICKS+TOL+1 while still in phase, fault_code 4 SHALL be set on that edge.
REQ-013 Simultaneous conditions SHALL resolve by priority 1 > 2 > 3 > 4.
REQ-014 On any fault: fault=1, fault_code latched, FSM enters FAULT and stays until reset; phase, cycle_count and last_len freeze.
REQ-015 On every checked or unchecked phase exit, last_len SHALL load the completed count.
REQ-016 cycle_count SHALL increment on each legal YELLOW->RED transition, wrapping 255->0.

Reset
REQ-017 Reset SHALL clear stage-1 registers, counter, phase=0, fault=0, fault_code=0, cycle_count=0, last_len=0, and enter SYNC.
REQ-018 Reset asserted mid-phase or in FAULT SHALL take priority over all other updates on that edge.

Structure
REQ-019 Package traffic_light_pkg SHALL hold phase encodings, fault code constants and default tick values.
REQ-020 One sub-module phase_timer SHALL implement the saturating counter and min/max compares.

Verification
REQ-021 Reset, then red 10/green 8/yellow 3 cycles x3 starting from red -> fault=0, cycle_count=3 (first red unchecked), last_len=3 at end.
REQ-022 During checked green, red=green=1 for one cycle -> fault=1, fault_code=1 two edges later; held after inputs recover.
REQ-023 Red 10 then directly yellow -> fault_code=2, phase frozen at 1.
REQ-024 After legal red, green held 5 cycles then yellow -> fault_code=3, last_len=5.
REQ-025 Checked red held 12 cycles -> fault_code=4 on the edge the count would reach 12.
REQ-026 Reset during FAULT, then green 2 cycles -> yellow 3 -> no fault, phase=3, last_len=2.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared encodings, defaults and decode helpers for the traffic light monitor.
// Phase values double as the external phase output encoding.
package traffic_light_pkg;

    localparam int unsigned CNT_W = 8;

    localparam int unsigned DEF_RED_TICKS    = 10;
    localparam int unsigned DEF_GREEN_TICKS  = 8;
    localparam int unsigned DEF_YELLOW_TICKS = 3;
    localparam int unsigned DEF_TOL          = 1;

    localparam logic [1:0] PH_SYNC   = 2'd0;
    localparam logic [1:0] PH_RED    = 2'd1;
    localparam logic [1:0] PH_GREEN  = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;

    localparam logic [2:0] FC_NONE   = 3'd0;
    localparam logic [2:0] FC_ONEHOT = 3'd1;
    localparam logic [2:0] FC_ORDER  = 3'd2;
    localparam logic [2:0] FC_SHORT  = 3'd3;
    localparam logic [2:0] FC_LONG   = 3'd4;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_RED    = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    // Lamps packed as {red, green, yellow}; anything not one-hot decodes to PH_SYNC.
    function automatic logic [1:0] lamp_phase(input logic [2:0] lamps);
        case (lamps)
            3'b100:  lamp_phase = PH_RED;
            3'b010:  lamp_phase = PH_GREEN;
            3'b001:  lamp_phase = PH_YELLOW;
            default: lamp_phase = PH_SYNC;
        endcase
    endfunction

    function automatic logic [1:0] state_phase(input state_e st);
        case (st)
            ST_RED:    state_phase = PH_RED;
            ST_GREEN:  state_phase = PH_GREEN;
            ST_YELLOW: state_phase = PH_YELLOW;
            default:   state_phase = PH_SYNC;
        endcase
    endfunction

    function automatic state_e phase_state(input logic [1:0] ph);
        case (ph)
            PH_RED:    phase_state = ST_RED;
            PH_GREEN:  phase_state = ST_GREEN;
            PH_YELLOW: phase_state = ST_YELLOW;
            default:   phase_state = ST_SYNC;
        endcase
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        case (ph)
            PH_RED:    next_phase = PH_GREEN;
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            default:   next_phase = PH_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_phase_timer.sv
// Saturating per-phase length counter with min/max window compares.
module phase_timer
    import traffic_light_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] min_len,
    input  logic [CNT_W-1:0] max_len,
    output logic [CNT_W-1:0] count,
    output logic             too_short_c,
    output logic             too_long_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CNT_W'(1);
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    // too_long_c means one more matching sample would exceed the window.
    assign too_short_c = (count_q < min_len);
    assign too_long_c  = (count_q >= max_len);

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches red/green/yellow lamps, tracks the phase sequence and latches the
// first ordering or timing violation as a sticky fault.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned RED_TICKS    = DEF_RED_TICKS,
    parameter int unsigned GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int unsigned YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int unsigned TOL          = DEF_TOL
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       red,
    input  logic       green,
    input  logic       yellow,
    output logic [1:0] phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_count,
    output logic [7:0] last_len
);

    localparam logic [CNT_W-1:0] RED_MIN    = CNT_W'(RED_TICKS - TOL);
    localparam logic [CNT_W-1:0] RED_MAX    = CNT_W'(RED_TICKS + TOL);
    localparam logic [CNT_W-1:0] GREEN_MIN  = CNT_W'(GREEN_TICKS - TOL);
    localparam logic [CNT_W-1:0] GREEN_MAX  = CNT_W'(GREEN_TICKS + TOL);
    localparam logic [CNT_W-1:0] YELLOW_MIN = CNT_W'(YELLOW_TICKS - TOL);
    localparam logic [CNT_W-1:0] YELLOW_MAX = CNT_W'(YELLOW_TICKS + TOL);

    logic [2:0]       lamps_q, lamps_d;
    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] last_len_q, last_len_d;
    logic             checked_q, checked_d;

    logic [1:0]       samp_ph_c;
    logic [1:0]       cur_ph_c;
    logic [2:0]       code_c;
    logic             enter_c;
    logic             len_load_c;
    logic             cyc_inc_c;
    logic             inc_c;
    logic [CNT_W-1:0] min_len_c;
    logic [CNT_W-1:0] max_len_c;
    logic [CNT_W-1:0] count;
    logic             too_short_c;
    logic             too_long_c;

    always_comb begin
        lamps_d = {red, green, yellow};
    end

    assign samp_ph_c = lamp_phase(lamps_q);
    assign cur_ph_c  = state_phase(state_q);

    // Length window of the phase currently being timed.
    always_comb begin
        min_len_c = RED_MIN;
        max_len_c = RED_MAX;
        case (state_q)
            ST_GREEN: begin
                min_len_c = GREEN_MIN;
                max_len_c = GREEN_MAX;
            end
            ST_YELLOW: begin
                min_len_c = YELLOW_MIN;
                max_len_c = YELLOW_MAX;
            end
            default: ;
        endcase
    end

    phase_timer u_phase_timer (
        .clock       (clock),
        .reset       (reset),
        .load        (enter_c),
        .inc         (inc_c),
        .min_len     (min_len_c),
        .max_len     (max_len_c),
        .count       (count),
        .too_short_c (too_short_c),
        .too_long_c  (too_long_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            lamps_q       <= '0;
            state_q       <= ST_SYNC;
            phase_q       <= PH_SYNC;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            cycle_count_q <= '0;
            last_len_q    <= '0;
            checked_q     <= 1'b0;
        end else begin
            lamps_q       <= lamps_d;
            state_q       <= state_d;
            phase_q       <= phase_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            cycle_count_q <= cycle_count_d;
            last_len_q    <= last_len_d;
            checked_q     <= checked_d;
        end
    end

    // Next state and event decode; fault codes are tested in priority order.
    always_comb begin
        state_d    = state_q;
        code_c     = FC_NONE;
        enter_c    = 1'b0;
        len_load_c = 1'b0;
        cyc_inc_c  = 1'b0;
        inc_c      = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (samp_ph_c != PH_SYNC) begin
                    state_d = phase_state(samp_ph_c);
                    enter_c = 1'b1;
                end
            end
            ST_RED, ST_GREEN, ST_YELLOW: begin
                if (samp_ph_c == PH_SYNC) begin
                    code_c = FC_ONEHOT;
                end else if (samp_ph_c == cur_ph_c) begin
                    if (checked_q && too_long_c) begin
                        code_c = FC_LONG;
                    end else begin
                        inc_c = 1'b1;
                    end
                end else if (samp_ph_c != next_phase(cur_ph_c)) begin
                    code_c = FC_ORDER;
                end else begin
                    len_load_c = 1'b1;
                    if (checked_q && too_short_c) begin
                        code_c = FC_SHORT;
                    end else begin
                        state_d   = phase_state(samp_ph_c);
                        enter_c   = 1'b1;
                        cyc_inc_c = (state_q == ST_YELLOW);
                    end
                end
                if (code_c != FC_NONE) begin
                    state_d = ST_FAULT;
                end
            end
            default: ;
        endcase
    end

    // Output register updates; all of them hold once FAULT is reached.
    always_comb begin
        phase_d       = phase_q;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        cycle_count_d = cycle_count_q;
        last_len_d    = last_len_q;
        checked_d     = checked_q;
        if (code_c != FC_NONE) begin
            fault_d      = 1'b1;
            fault_code_d = code_c;
        end
        if (len_load_c) begin
            last_len_d = count;
        end
        if (enter_c) begin
            phase_d = state_phase(state_d);
            if (state_q != ST_SYNC) begin
                checked_d = 1'b1;
            end
        end
        if (cyc_inc_c) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
    end

    assign phase       = phase_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign cycle_count = cycle_count_q;
    assign last_len    = last_len_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with hand-computed expectations.
// Lamps change on the falling edge; outputs are read on the falling edge.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_G   = 3'b010;
    localparam logic [2:0] L_Y   = 3'b001;
    localparam logic [2:0] L_RG  = 3'b110;

    logic       clock;
    logic       reset;
    logic       red;
    logic       green;
    logic       yellow;
    logic [1:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_count;
    logic [7:0] last_len;

    int unsigned n_tests;
    int unsigned n_fail;

    traffic_light_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .red         (red),
        .green       (green),
        .yellow      (yellow),
        .phase       (phase),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count),
        .last_len    (last_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Each call presents one lamp pattern per clock, returning on a falling edge.
    task automatic apply(input logic [2:0] lamps, input int n);
        for (int i = 0; i < n; i++) begin
            {red, green, yellow} = lamps;
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {red, green, yellow} = L_OFF;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        {red, green, yellow} = L_OFF;
        @(negedge clock);
        do_reset();

        check_eq("rst_phase", phase, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_code", fault_code, 0);
        check_eq("rst_cycles", cycle_count, 0);
        check_eq("rst_last_len", last_len, 0);

        // Idle and multi-hot lamps keep SYNC without a fault.
        apply(L_OFF, 3);
        apply(L_RG, 2);
        apply(L_R, 1);
        check_eq("sync_phase", phase, 0);
        check_eq("sync_fault", fault, 0);

        // Three nominal cycles, then red again to close the third cycle.
        apply(L_R, 9);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) apply(L_R, 10);
            apply(L_G, 8);
            apply(L_Y, 3);
        end
        apply(L_R, 2);
        check_eq("nom_fault", fault, 0);
        check_eq("nom_cycles", cycle_count, 3);
        check_eq("nom_last_len", last_len, 3);
        check_eq("nom_phase", phase, 1);

        // Boundary lengths: green at max (9), yellow at min (2).
        do_reset();
        apply(L_R, 10);
        apply(L_G, 9);
        apply(L_Y, 2);
        apply(L_R, 2);
        check_eq("edge_fault", fault, 0);
        check_eq("edge_cycles", cycle_count, 1);
        check_eq("edge_last_len", last_len, 2);

        // Multi-hot during checked green: fault appears two edges later and sticks.
        do_reset();
        apply(L_R, 10);
        apply(L_G, 3);
        apply(L_RG, 1);
        check_eq("oh_not_yet", fault, 0);
        apply(L_G, 1);
        check_eq("oh_fault", fault, 1);
        check_eq("oh_code", fault_code, 1);
        apply(L_G, 4);
        check_eq("oh_code_held", fault_code, 1);
        check_eq("oh_phase_held", phase, 2);

        // Red straight to yellow is an illegal order.
        do_reset();
        apply(L_R, 10);
        apply(L_Y, 1);
        check_eq("ord_not_yet", fault, 0);
        apply(L_Y, 1);
        check_eq("ord_code", fault_code, 2);
        check_eq("ord_phase", phase, 1);

        // Checked green of only 5 cycles is too short.
        do_reset();
        apply(L_R, 10);
        apply(L_G, 5);
        apply(L_Y, 2);
        check_eq("short_code", fault_code, 3);
        check_eq("short_last_len", last_len, 5);
        check_eq("short_phase", phase, 2);

        // Checked red held too long: 11 is legal, the 12th sample faults.
        do_reset();
        apply(L_Y, 3);
        apply(L_R, 12);
        check_eq("long_at_11", fault, 0);
        check_eq("long_last_len", last_len, 3);
        apply(L_R, 1);
        check_eq("long_code", fault_code, 4);
        check_eq("long_phase", phase, 1);

        // Reset out of FAULT, then an unchecked short green.
        do_reset();
        check_eq("rf_fault_clr", fault, 0);
        check_eq("rf_code_clr", fault_code, 0);
        apply(L_G, 2);
        apply(L_Y, 4);
        check_eq("rf_fault", fault, 0);
        check_eq("rf_phase", phase, 3);
        check_eq("rf_last_len", last_len, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
